// File: rtl/sargantana_itag_sweep_memory.sv
// sargantana_itag_sweep_memory
// Instruction-cache tag store: N_WAYS x N_SETS tags with valid bits, a single
// request port with ready/valid handshake, registered per-way hit compare, and
// a set-by-set valid-bit sweep after reset (INIT) and on flush (FLUSH).
// Optional feature macro: ICACHE_TAG_PARITY_EN (per-entry even tag parity).
module sargantana_itag_sweep_memory #(
    parameter  int unsigned N_WAYS = 4,
    parameter  int unsigned N_SETS = 64,
    parameter  int unsigned TAG_W  = 20,
    localparam int unsigned SET_W  = $clog2(N_SETS)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [N_WAYS-1:0]         way_we_i,
    input  logic [SET_W-1:0]          set_i,
    input  logic [TAG_W-1:0]          tag_i,
    input  logic                      vbit_i,
    input  logic                      flush_i,
    output logic                      ready_o,
    output logic                      rvalid_o,
    output logic [N_WAYS*TAG_W-1:0]   tag_way_o,
    output logic [N_WAYS-1:0]         vbit_o,
    output logic [N_WAYS-1:0]         hit_way_o,
    output logic                      hit_o,
    output logic [N_WAYS-1:0]         par_err_o
);

    localparam logic [SET_W-1:0] LAST_SET = SET_W'(N_SETS - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SET_W-1:0]   cnt_q, cnt_d;

    logic               ready_q, ready_d;
    logic               sweep_c;
    logic               accept_c;
    logic               wr_c;
    logic               rd_c;

    // Storage: tags keep their contents across reset; valid bits are cleared by the sweep
    logic [TAG_W-1:0]   tag_q   [N_WAYS][N_SETS];
    logic               valid_q [N_WAYS][N_SETS];

    logic [N_WAYS*TAG_W-1:0] tag_way_c;
    logic [N_WAYS-1:0]       vbit_c;
    logic [N_WAYS-1:0]       hit_way_c;
    logic [N_WAYS-1:0]       par_err_c;

    logic                    rvalid_q;
    logic [N_WAYS*TAG_W-1:0] tag_way_q;
    logic [N_WAYS-1:0]       vbit_q;
    logic [N_WAYS-1:0]       hit_way_q;
    logic                    hit_q;
    logic [N_WAYS-1:0]       par_err_q;

    // FSM state and sweep counter register; reset restarts the INIT sweep
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: sweep one set per cycle, flush only honoured from IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT, ST_FLUSH: begin
                cnt_d = cnt_q + SET_W'(1);
                if (cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: registered ready follows next state; flush beats a same-cycle request
    always_comb begin
        ready_d  = (state_d == ST_IDLE);
        sweep_c  = rstn_i & ((state_q == ST_INIT) | (state_q == ST_FLUSH));
        accept_c = rstn_i & req_i & ready_q & ~flush_i;
        wr_c     = accept_c & we_i;
        rd_c     = accept_c & ~we_i;
    end

    // Tag array write
    always_ff @(posedge clk_i) begin
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            if (wr_c && way_we_i[w]) begin
                tag_q[w][set_i] <= tag_i;
            end
        end
    end

    // Valid array: sweep clears one set across all ways, otherwise masked writes
    always_ff @(posedge clk_i) begin
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            if (sweep_c) begin
                valid_q[w][cnt_q] <= 1'b0;
            end else if (wr_c && way_we_i[w]) begin
                valid_q[w][set_i] <= vbit_i;
            end
        end
    end

`ifdef ICACHE_TAG_PARITY_EN
    logic par_q [N_WAYS][N_SETS];

    // Parity array: even parity of the written tag, untouched by the sweep
    always_ff @(posedge clk_i) begin
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            if (wr_c && way_we_i[w]) begin
                par_q[w][set_i] <= ^tag_i;
            end
        end
    end

    // Per-way parity check on the addressed set
    always_comb begin
        par_err_c = '0;
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            par_err_c[w] = valid_q[w][set_i] & ((^tag_q[w][set_i]) != par_q[w][set_i]);
        end
    end
`else
    // No parity storage in this build
    always_comb begin
        par_err_c = '0;
    end
`endif

    // Read lookup of the addressed set; a parity-failing way never hits
    always_comb begin
        tag_way_c = '0;
        vbit_c    = '0;
        hit_way_c = '0;
        for (int unsigned w = 0; w < N_WAYS; w++) begin
            tag_way_c[w*TAG_W +: TAG_W] = tag_q[w][set_i];
            vbit_c[w]    = valid_q[w][set_i];
            hit_way_c[w] = valid_q[w][set_i] & (tag_q[w][set_i] == tag_i) & ~par_err_c[w];
        end
    end

    // Output registers: read results captured on an accepted read, held otherwise
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            tag_way_q <= '0;
            vbit_q    <= '0;
            hit_way_q <= '0;
            hit_q     <= 1'b0;
            par_err_q <= '0;
        end else begin
            ready_q  <= ready_d;
            rvalid_q <= rd_c;
            if (rd_c) begin
                tag_way_q <= tag_way_c;
                vbit_q    <= vbit_c;
                hit_way_q <= hit_way_c;
                hit_q     <= |hit_way_c;
                par_err_q <= par_err_c;
            end
        end
    end

    assign ready_o   = ready_q;
    assign rvalid_o  = rvalid_q;
    assign tag_way_o = tag_way_q;
    assign vbit_o    = vbit_q;
    assign hit_way_o = hit_way_q;
    assign hit_o     = hit_q;
    assign par_err_o = par_err_q;

endmodule

// File: tb/tb_sargantana_itag_sweep_memory.sv
// Directed scoreboard bench for sargantana_itag_sweep_memory (default parameters).
module tb_sargantana_itag_sweep_memory;

    localparam int unsigned NW = 4;
    localparam int unsigned NS = 64;
    localparam int unsigned TW = 20;
    localparam int unsigned SW = 6;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              req_i;
    logic              we_i;
    logic [NW-1:0]     way_we_i;
    logic [SW-1:0]     set_i;
    logic [TW-1:0]     tag_i;
    logic              vbit_i;
    logic              flush_i;
    logic              ready_o;
    logic              rvalid_o;
    logic [NW*TW-1:0]  tag_way_o;
    logic [NW-1:0]     vbit_o;
    logic [NW-1:0]     hit_way_o;
    logic              hit_o;
    logic [NW-1:0]     par_err_o;

    sargantana_itag_sweep_memory #(.N_WAYS(NW), .N_SETS(NS), .TAG_W(TW)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .way_we_i  (way_we_i),
        .set_i     (set_i),
        .tag_i     (tag_i),
        .vbit_i    (vbit_i),
        .flush_i   (flush_i),
        .ready_o   (ready_o),
        .rvalid_o  (rvalid_o),
        .tag_way_o (tag_way_o),
        .vbit_o    (vbit_o),
        .hit_way_o (hit_way_o),
        .hit_o     (hit_o),
        .par_err_o (par_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NW*TW-1:0] tw;
        logic [NW*TW-1:0] tmask;
        logic [NW-1:0]    vb;
        logic [NW-1:0]    hw;
        logic [NW-1:0]    pe;
    } exp_t;

    exp_t sb[$];

    logic [TW-1:0] mt [NW][NS];
    bit            mv [NW][NS];
    bit            mk [NW][NS];
    bit            mc [NW][NS];

    int total = 0;
    int bad   = 0;
    int ncyc;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear_valid();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++)
                mv[w][s] = 1'b0;
    endtask

    task automatic do_write(input int s, input logic [NW-1:0] mask, input logic [TW-1:0] t, input logic v);
        req_i = 1'b1; we_i = 1'b1; set_i = SW'(s); way_we_i = mask; tag_i = t; vbit_i = v;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0; way_we_i = '0;
        for (int w = 0; w < NW; w++) begin
            if (mask[w]) begin
                mt[w][s] = t; mv[w][s] = v; mk[w][s] = 1'b1; mc[w][s] = 1'b0;
            end
        end
        chk("write_no_rvalid", 128'(rvalid_o), 128'(1'b0));
    endtask

    task automatic do_read(input string name, input int s, input logic [TW-1:0] t);
        exp_t e;
        exp_t got;
        e.tw = '0; e.tmask = '0; e.vb = '0; e.hw = '0; e.pe = '0;
        for (int w = 0; w < NW; w++) begin
            e.vb[w] = mv[w][s];
            e.pe[w] = mv[w][s] & mc[w][s];
            e.hw[w] = mv[w][s] & mk[w][s] & (mt[w][s] == t) & ~e.pe[w];
            if (mk[w][s]) begin
                e.tw[w*TW +: TW]    = mt[w][s];
                e.tmask[w*TW +: TW] = '1;
            end
        end
        sb.push_back(e);
        req_i = 1'b1; we_i = 1'b0; set_i = SW'(s); tag_i = t;
        @(negedge clk_i);
        req_i = 1'b0;
        chk({name, "_rvalid"}, 128'(rvalid_o), 128'(1'b1));
        if (sb.size() != 0) begin
            got = sb.pop_front();
            if (rvalid_o) begin
                chk({name, "_vbit"},    128'(vbit_o),    128'(got.vb));
                chk({name, "_hitway"},  128'(hit_way_o), 128'(got.hw));
                chk({name, "_hit"},     128'(hit_o),     128'(|got.hw));
                chk({name, "_parerr"},  128'(par_err_o), 128'(got.pe));
                chk({name, "_tagway"},  128'(tag_way_o & got.tmask), 128'(got.tw & got.tmask));
            end
        end
        @(negedge clk_i);
        chk({name, "_pulse"}, 128'(rvalid_o), 128'(1'b0));
    endtask

    // Count cycles with ready_o low (bounded); optionally pulse flush_i at cycle flush_at
    task automatic wait_ready(input int flush_at, output int n);
        n = 0;
        while (!ready_o && n < 200) begin
            n++;
            flush_i = (n == flush_at);
            @(negedge clk_i);
        end
        flush_i = 1'b0;
    endtask

    initial begin
        rstn_i = 1'b0; req_i = 1'b0; we_i = 1'b0; way_we_i = '0; set_i = '0;
        tag_i = '0; vbit_i = 1'b0; flush_i = 1'b0;
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) begin
                mt[w][s] = '0; mv[w][s] = 1'b0; mk[w][s] = 1'b0; mc[w][s] = 1'b0;
            end

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_ready",  128'(ready_o),   128'(1'b0));
        chk("rst_rvalid", 128'(rvalid_o),  128'(1'b0));
        chk("rst_hit",    128'(hit_o),     128'(1'b0));
        chk("rst_hitway", 128'(hit_way_o), 128'(0));
        chk("rst_vbit",   128'(vbit_o),    128'(0));
        chk("rst_tagway", 128'(tag_way_o), 128'(0));
        chk("rst_parerr", 128'(par_err_o), 128'(0));

        // INIT sweep length
        rstn_i = 1'b1;
        wait_ready(0, ncyc);
        chk("init_len", 128'(ncyc), 128'(NS));
        chk("init_ready", 128'(ready_o), 128'(1'b1));
        do_read("init_rd9", 9, 20'h00009);
        do_read("init_rd63", 63, 20'h00000);

        // Single-way write then lookups
        do_write(5, 4'b0100, 20'h1ABCD, 1'b1);
        do_read("hit5", 5, 20'h1ABCD);
        do_read("miss5", 5, 20'h1ABCE);
        do_read("rd6", 6, 20'h1ABCD);

        // Multi-way write, multiple simultaneous hits, then invalidate one way
        do_write(7, 4'b1011, 20'h00042, 1'b1);
        do_read("multi7", 7, 20'h00042);
        do_write(7, 4'b0001, 20'h00042, 1'b0);
        do_read("inval7", 7, 20'h00042);
        do_write(8, 4'b0000, 20'hFFFFF, 1'b1);
        do_read("nomask8", 8, 20'hFFFFF);
        do_write(63, 4'b1000, 20'hFFFFF, 1'b1);
        do_read("set63", 63, 20'hFFFFF);

        // Flush wins over same-cycle request; second flush mid-sweep ignored
        flush_i = 1'b1; req_i = 1'b1; we_i = 1'b0; set_i = SW'(5); tag_i = 20'h1ABCD;
        @(negedge clk_i);
        flush_i = 1'b0; req_i = 1'b0;
        model_clear_valid();
        chk("flush_ready", 128'(ready_o), 128'(1'b0));
        chk("flush_drop_req", 128'(rvalid_o), 128'(1'b0));
        wait_ready(10, ncyc);
        chk("flush_len", 128'(ncyc), 128'(NS));
        do_read("post_flush5", 5, 20'h1ABCD);

        // Reset mid-FLUSH: outputs clear and a full INIT follows
        do_write(3, 4'b0010, 20'h0BEEF, 1'b1);
        do_read("pre_rst3", 3, 20'h0BEEF);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        repeat (30) @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        model_clear_valid();
        chk("mid_rst_hit",    128'(hit_o),     128'(1'b0));
        chk("mid_rst_tagway", 128'(tag_way_o), 128'(0));
        chk("mid_rst_vbit",   128'(vbit_o),    128'(0));
        chk("mid_rst_ready",  128'(ready_o),   128'(1'b0));
        rstn_i = 1'b1;
        wait_ready(0, ncyc);
        chk("reinit_len", 128'(ncyc), 128'(NS));
        do_read("reinit_rd3", 3, 20'h0BEEF);

        // Parity: stored tag corrupted behind the design's back
        do_write(12, 4'b0010, 20'h12345, 1'b1);
`ifdef ICACHE_TAG_PARITY_EN
        dut.tag_q[1][12] = dut.tag_q[1][12] ^ 20'h00008;
        mt[1][12] = 20'h12345 ^ 20'h00008;
        mc[1][12] = 1'b1;
        do_read("par12", 12, 20'h12345 ^ 20'h00008);
`else
        do_read("par12", 12, 20'h12345);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
